// File: rtl/moore_defs.sv
// Shared definitions for the up/down Moore counter: display state codes,
// sequencer FSM encoding and the highest legal counter state.
package moore_defs;

  localparam logic [3:0] ST_A = 4'd0;
  localparam logic [3:0] ST_B = 4'd1;
  localparam logic [3:0] ST_C = 4'd2;
  localparam logic [3:0] ST_D = 4'd3;
  localparam logic [3:0] ST_E = 4'd4;
  localparam logic [3:0] ST_F = 4'd5;
  localparam logic [3:0] ST_G = 4'd6;
  localparam logic [3:0] ST_H = 4'd7;
  localparam logic [3:0] ST_I = 4'd8;
  localparam logic [3:0] ST_J = 4'd9;

  localparam logic [3:0] MAX_VALID = 4'd9;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    APPLY    = 3'd2,
    WAIT_REL = 3'd3,
    LOCK     = 3'd4
  } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for asynchronous push-button inputs.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/moore_sequenciador.sv
// Sequencing controller for the 10-state up/down Moore counter: debounces the
// buttons into single-cycle step strobes and owns ATUAL. Option: MOORE_AUTO_REPEAT_EN.
module moore_sequenciador
  import moore_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 1000,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  input  logic       CLR,
  input  logic [3:0] PROX,
  output logic       UP,
  output logic       DOWN,
  output logic [3:0] ATUAL,
  output logic       ERR,
  output logic       WRAP
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || $clog2(CNT_MAX) > CNT_W) begin : g_bad_cfg
    $error("moore_sequenciador: DEBOUNCE_CYCLES < 2 or CNT_W too narrow");
  end

  logic       up_s, dn_s;
  logic [1:0] pat;

  sync_2ff u_sync_up (.clk(CLK), .rst(RST), .d(BTN_UP),   .q(up_s));
  sync_2ff u_sync_dn (.clk(CLK), .rst(RST), .d(BTN_DOWN), .q(dn_s));

  assign pat = {up_s, dn_s};

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cap_q, cap_d;
  logic [3:0]       atual_q, atual_d;
  logic             wrap_q, wrap_d;

`ifdef MOORE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  // Remembers whether the last WAIT_REL cycle was counting a hold, so the
  // shared counter restarts when the pattern switches between hold and release.
  logic hold_q, hold_d;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= 2'b00;
      atual_q <= ST_A;
      wrap_q  <= 1'b0;
`ifdef MOORE_AUTO_REPEAT_EN
      hold_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      atual_q <= atual_d;
      wrap_q  <= wrap_d;
`ifdef MOORE_AUTO_REPEAT_EN
      hold_q  <= hold_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    atual_d = atual_q;
    wrap_d  = 1'b0;
    UP      = 1'b0;
    DOWN    = 1'b0;
`ifdef MOORE_AUTO_REPEAT_EN
    hold_d  = hold_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (pat != 2'b00) begin
          cap_d   = pat;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (pat != cap_q)          state_d = IDLE;
        else if (cnt_q == DEB_LAST) state_d = APPLY;
        else                        cnt_d = cnt_q + 1'b1;
      end
      APPLY: begin
        UP     = cap_q[1];
        DOWN   = cap_q[0];
        cnt_d  = '0;
        wrap_d = (cap_q == 2'b10 && atual_q == ST_I && PROX == ST_A) ||
                 (cap_q == 2'b01 && atual_q == ST_A && PROX == ST_I);
`ifdef MOORE_AUTO_REPEAT_EN
        hold_d = 1'b1;
`endif
        if (cap_q == 2'b11 || PROX > MAX_VALID) begin
          atual_d = ST_J;
          state_d = LOCK;
        end else begin
          atual_d = PROX;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
`ifdef MOORE_AUTO_REPEAT_EN
        if (pat == 2'b00) begin
          hold_d = 1'b0;
          if (hold_q)                 cnt_d = CNT_W'(1);
          else if (cnt_q == DEB_LAST) state_d = IDLE;
          else                        cnt_d = cnt_q + 1'b1;
        end else if (pat == cap_q && cap_q != 2'b11) begin
          hold_d = 1'b1;
          if (!hold_q) cnt_d = CNT_W'(1);
          else if (cnt_q == REP_LAST) begin
            cnt_d   = '0;
            state_d = APPLY;
          end else cnt_d = cnt_q + 1'b1;
        end else begin
          hold_d = 1'b0;
          cnt_d  = '0;
        end
`else
        if (pat != 2'b00)           cnt_d = '0;
        else if (cnt_q == DEB_LAST) state_d = IDLE;
        else                        cnt_d = cnt_q + 1'b1;
`endif
      end
      LOCK: begin
      end
      default: state_d = IDLE;
    endcase

    // Clearing the capture keeps a still-held button from re-arming a step.
    if (CLR) begin
      atual_d = ST_A;
      cnt_d   = '0;
      cap_d   = 2'b00;
      wrap_d  = 1'b0;
      state_d = WAIT_REL;
`ifdef MOORE_AUTO_REPEAT_EN
      hold_d  = 1'b0;
`endif
    end
  end

  assign ATUAL = atual_q;
  assign ERR   = (atual_q == ST_J);
  assign WRAP  = wrap_q;

endmodule

// File: doc/moore_sequenciador.md
Name: moore_sequenciador

Overview:
- Sequencing controller for the 10-state up/down Moore counter.
- Owns the state register ATUAL.
- Turns raw UP/DOWN push-buttons into synchronized, debounced, single-cycle step strobes for the combinational next-state logic.
- Registers that logic's PROX result, locks in error state J when both buttons are pressed, and flags wrap-around.
- Sits between the board push-buttons and the next-state logic / 7-segment display decoder.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable cycles required to accept a press or a release (min 2).
- REPEAT_CYCLES, 1000: hold time between auto-repeat steps (used only with the optional feature).
- CNT_W, 16: width of the shared debounce/repeat counter; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-high
- BTN_UP  in  1  raw up button, asynchronous, active-high
- BTN_DOWN  in  1  raw down button, asynchronous, active-high
- CLR  in  1  synchronous clear of the error lock / counter, active-high, sampled every cycle
- PROX  in  4  next state from the next-state logic, a function of (UP, DOWN, ATUAL)
- UP  out  1  step-up strobe to the next-state logic
- DOWN  out  1  step-down strobe to the next-state logic
- ATUAL  out  4  registered current state: A=0000 … I=1000, J=1001 (error)
- ERR  out  1  high while ATUAL==J
- WRAP  out  1  one-cycle pulse when a step wraps I→A (up) or A→I (down)

Behaviour:
- Reset (async, RST=1): ATUAL=A, UP=0, DOWN=0, ERR=0, WRAP=0, synchronizers cleared, counter=0, FSM=IDLE.
- Input path: 2-flop synchronizer on each button gives sync pattern P={up,down}. Captured pattern is C.
- FSM states: IDLE, DEBOUNCE, APPLY, WAIT_REL, LOCK.
- IDLE:
  - P≠00 → C=P, counter=0, go to DEBOUNCE.
- DEBOUNCE:
  - P≠C → IDLE (glitch rejected, no step).
  - Otherwise counter++; when counter==DEBOUNCE_CYCLES-1 → APPLY.
- APPLY (exactly one cycle):
  - Drive UP=C[1], DOWN=C[0] combinationally from state; ATUAL<=PROX at the end of the cycle.
  - C==11, or PROX>4'd9 → ATUAL<=J, go to LOCK.
  - Otherwise → WAIT_REL, counter=0.
- WAIT_REL:
  - Requires P==00 for DEBOUNCE_CYCLES consecutive cycles → IDLE.
  - Any P≠00 restarts the count.
  - A new press is not accepted until release is confirmed.
- LOCK: ATUAL held at J, ERR=1, buttons ignored.
- UP/DOWN are 0 in every state except APPLY, so the next-state logic sees "hold". ATUAL changes only in APPLY or on CLR/reset.
- Latency: a clean press stable from edge 0 updates ATUAL on edge DEBOUNCE_CYCLES+4. Breakdown: 2 sync, 1 IDLE, DEBOUNCE_CYCLES debounce, 1 APPLY.
- WRAP: registered. Asserted for the single cycle after APPLY if (C==10, ATUAL==I, PROX==A) or (C==01, ATUAL==A, PROX==I).
- CLR has priority over everything except RST, in any state: ATUAL<=A, ERR<=0, counter=0, go to WAIT_REL, so a button still held causes no step.
- Simultaneous press: both buttons arriving within the debounce window with different timing restarts DEBOUNCE via P≠C. Only a stable 11 reaches APPLY and goes to LOCK.
- Reset mid-operation: immediate return to reset values; any in-flight step is lost.

Optional Feature:
- Macro: MOORE_AUTO_REPEAT_EN.
- Defined: in WAIT_REL, if P==C, C is a single button (10 or 01), and P has held for REPEAT_CYCLES consecutive cycles → APPLY again, counter=0. This repeats every REPEAT_CYCLES+1 cycles while held.
- Undefined: one step per press; WAIT_REL only waits for release.

Decomposition:
- Shared header/package moore_defs:
  - state codes A..J
  - FSM state encodings IDLE..LOCK
  - MAX_VALID=4'd9
- Sub-module sync_2ff: 1-bit two-flop synchronizer, instantiated twice.
- Debounce counter and FSM stay in moore_sequenciador.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8):
- Reset, hold BTN_UP from edge 0 → ATUAL 0000→0001 on edge 8; UP high exactly one cycle; no further step while held (feature off).
- BTN_UP pulse of 3 cycles (glitch) → no APPLY, ATUAL unchanged, UP never asserted.
- Start at ATUAL=I (1000), press and release up → ATUAL=0000, WRAP=1 for one cycle. From A press down → ATUAL=1000, WRAP pulse.
- Both buttons stable 10 cycles → ATUAL=1001, ERR=1. Further presses are ignored. CLR pulse → ATUAL=0000, ERR=0; held buttons cause no step until release.
- RST asserted mid-DEBOUNCE → outputs immediately at reset values; after release, a fresh press still takes DEBOUNCE_CYCLES+4 edges.
- With MOORE_AUTO_REPEAT_EN, hold BTN_DOWN from ATUAL=0101 → steps to 0100, 0011, 0010 spaced 9 cycles apart.
